instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 118 +++++++++++
 tb/tb_instr_fetch.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one word-addressed read at a time to
// instruction memory and queues returned words (with their addresses)
// for decode. A branch flushes the queue and discards any in-flight read.
module instr_fetch #(
  parameter int unsigned size  = 32,
  parameter int unsigned IW    = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [size-1:0] pc,
  input  logic            pc_valid,
  output logic            pc_ready,
  input  logic            branch,
  output logic            imem_req,
  output logic [size-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [IW-1:0]   imem_rdata,
  output logic [IW-1:0]   instr,
  output logic [size-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t state, state_next;

  logic [IW-1:0]   mem_instr [DEPTH];
  logic [size-1:0] mem_pc    [DEPTH];
  logic [AW-1:0]   head, tail, next_head;
  logic [AW:0]     count, count_after_pop, next_count;
  logic            accept, push, pop;

  assign instr_valid = (count != '0);
  assign pc_ready    = (state == IDLE) && (count < DEPTH_C) && !branch;
  // A request is outstanding exactly while the FSM is out of IDLE, so the
  // request line follows the state and drops with it on reset.
  assign imem_req    = (state != IDLE);

  // Handshake decode, queue arithmetic and next-state selection
  always_comb begin
    accept          = pc_valid && pc_ready;
    push            = (state == REQ) && imem_ack && !branch;
    pop             = instr_valid && instr_ready && !branch;
    count_after_pop = count - (AW + 1)'(pop);
    next_count      = count_after_pop + (AW + 1)'(push);
    next_head       = head + AW'(pop);
    state_next      = state;
    unique case (state)
      IDLE: if (accept) state_next = REQ;
      REQ: begin
        if (imem_ack)    state_next = IDLE;
        else if (branch) state_next = DROP;
      end
      DROP: if (imem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Capture the fetch address on accept; held for the life of the request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      imem_addr <= '0;
    else if (accept) imem_addr <= pc;
  end

  // Queue storage, written at the tail on each accepted memory return
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[tail] <= imem_rdata;
      mem_pc[tail]    <= imem_addr;
    end
  end

  // Queue pointers, occupancy and registered head view
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      instr    <= '0;
      instr_pc <= '0;
    end else if (branch) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= next_head;
      count <= next_count;
      if (push) tail <= tail + AW'(1);
      // The head view is registered; when the queue drains to the pushed
      // word in the same edge, bypass storage and take the incoming data.
      if (next_count != '0) begin
        if (count_after_pop == '0) begin
          instr    <= imem_rdata;
          instr_pc <= imem_addr;
        end else begin
          instr    <= mem_instr[next_head];
          instr_pc <= mem_pc[next_head];
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with default parameters (DEPTH=2).
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        branch;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int errors = 0;
  int checks = 0;

  instr_fetch #(.size(32), .IW(32), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid),
    .pc_ready(pc_ready), .branch(branch), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one pc and return its word one cycle after the request appears
  task automatic fetch(input logic [31:0] a, input logic [31:0] d);
    pc = a; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_rdata = d; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; pc = '0; pc_valid = 1'b0; branch = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", instr_valid); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", imem_addr); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr_pc got %h want 0", instr_pc); end
    #1 reset = 1'b1;
    #1;
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL rst_pc_ready got %0b want 1", pc_ready); end
  endtask

  task automatic test_basic();
    // Stray ack while idle must not create an entry
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL idle_ack_valid got %0b want 0", instr_valid); end
    pc = 32'd5; pc_valid = 1'b1;
    #1;
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %0b want 1", pc_ready); end
    tick();
    pc_valid = 1'b0;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL basic_req got %0b want 1", imem_req); end
    checks++; if (imem_addr !== 32'd5) begin errors++; $display("FAIL basic_addr got %h want 5", imem_addr); end
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL basic_busy got %0b want 0", pc_ready); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_early got %0b want 0", instr_valid); end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", instr_valid); end
    checks++; if (instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_instr got %h want deadbeef", instr); end
    checks++; if (instr_pc !== 32'd5) begin errors++; $display("FAIL basic_instr_pc got %h want 5", instr_pc); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL basic_req_drop got %0b want 0", imem_req); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_pop got %0b want 0", instr_valid); end
    checks++; if (instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_hold got %h want deadbeef", instr); end
  endtask

  task automatic test_full();
    instr_ready = 1'b0;
    fetch(32'd0, 32'hA000_0000);
    fetch(32'd1, 32'hA000_0001);
    pc = 32'd2; pc_valid = 1'b1;
    #1;
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", pc_ready); end
    checks++; if (instr_pc !== 32'd0) begin errors++; $display("FAIL full_head got %h want 0", instr_pc); end
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_noreq got %0b want 0", imem_req); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    #1;
    checks++; if (instr_pc !== 32'd1) begin errors++; $display("FAIL full_pop_pc got %h want 1", instr_pc); end
    checks++; if (instr !== 32'hA000_0001) begin errors++; $display("FAIL full_pop_instr got %h want a0000001", instr); end
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL full_ready2 got %0b want 1", pc_ready); end
    tick();
    pc_valid = 1'b0;
    checks++; if (imem_addr !== 32'd2) begin errors++; $display("FAIL full_addr got %h want 2", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL full_req got %0b want 1", imem_req); end
    imem_ack = 1'b1; imem_rdata = 32'hA000_0002;
    tick();
    imem_ack = 1'b0;
    checks++; if (instr_pc !== 32'd1) begin errors++; $display("FAIL full_order1 got %h want 1", instr_pc); end
    instr_ready = 1'b1;
    tick();
    checks++; if (instr_pc !== 32'd2) begin errors++; $display("FAIL full_order2 got %h want 2", instr_pc); end
    checks++; if (instr !== 32'hA000_0002) begin errors++; $display("FAIL full_order2_instr got %h want a0000002", instr); end
    tick();
    instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL full_drain got %0b want 0", instr_valid); end
  endtask

  task automatic test_wrap_push_pop();
    branch = 1'b1;
    tick();
    branch = 1'b0;
    fetch(32'd10, 32'hB000_0010);
    pc = 32'd11; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hB000_0011; instr_ready = 1'b1;
    tick();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %0b want 1", instr_valid); end
    checks++; if (instr_pc !== 32'd11) begin errors++; $display("FAIL wrap_pc got %h want b", instr_pc); end
    checks++; if (instr !== 32'hB000_0011) begin errors++; $display("FAIL wrap_instr got %h want b0000011", instr); end
    instr_ready = 1'b0;
    #1;
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL wrap_count1 got %0b want 1", pc_ready); end
    fetch(32'd12, 32'hB000_0012);
    checks++; if (instr_pc !== 32'd11) begin errors++; $display("FAIL wrap_head got %h want b", instr_pc); end
    instr_ready = 1'b1;
    tick();
    checks++; if (instr_pc !== 32'd12) begin errors++; $display("FAIL wrap_next got %h want c", instr_pc); end
    tick();
    instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain got %0b want 0", instr_valid); end
  endtask

  task automatic test_branch_drop();
    pc = 32'd8; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    branch = 1'b1;
    #1;
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL drop_ready_br got %0b want 0", pc_ready); end
    tick();
    branch = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL drop_req got %0b want 1", imem_req); end
    checks++; if (imem_addr !== 32'd8) begin errors++; $display("FAIL drop_addr got %h want 8", imem_addr); end
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL drop_ready got %0b want 0", pc_ready); end
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL drop_hold got %0b want 1", imem_req); end
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0008;
    tick();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL drop_valid got %0b want 0", instr_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drop_req_end got %0b want 0", imem_req); end
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL drop_ready_end got %0b want 1", pc_ready); end
  endtask

  task automatic test_branch_ack();
    instr_ready = 1'b0;
    fetch(32'd3, 32'hC000_0003);
    fetch(32'd4, 32'hC000_0004);
    branch = 1'b1;
    tick();
    branch = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", instr_valid); end
    checks++; if (instr_pc !== 32'd3) begin errors++; $display("FAIL flush_hold got %h want 3", instr_pc); end
    fetch(32'd3, 32'hC000_0003);
    pc = 32'd4; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hC000_0004;
    branch = 1'b1; instr_ready = 1'b1;
    tick();
    imem_ack = 1'b0; branch = 1'b0; instr_ready = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL brack_valid got %0b want 0", instr_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL brack_req got %0b want 0", imem_req); end
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL brack_ready got %0b want 1", pc_ready); end
    fetch(32'd6, 32'hD000_0006);
    checks++; if (instr_pc !== 32'd6) begin errors++; $display("FAIL brack_next_pc got %h want 6", instr_pc); end
    checks++; if (instr !== 32'hD000_0006) begin errors++; $display("FAIL brack_next_instr got %h want d0000006", instr); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_reset_midreq();
    fetch(32'd7, 32'hE000_0007);
    pc = 32'd9; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    #3 reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL arst_req got %0b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0b want 0", instr_valid); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL arst_addr got %h want 0", imem_addr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL arst_instr_pc got %h want 0", instr_pc); end
    #2 reset = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'hE000_0009;
    tick();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL arst_stray got %0b want 0", instr_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL arst_stray_req got %0b want 0", imem_req); end
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %0b want 1", pc_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_wrap_push_pop();
    test_branch_drop();
    test_branch_ack();
    test_reset_midreq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
